// File: rtl/collatz_range_pkg.sv
// Shared types and widths for the collatz_range block.
package collatz_range_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned VAL_W   = 32;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/collatz_step.sv
// Collatz iterator datapath: value register, next-value logic and next-is-one flag.
// Optional macro COLLATZ_RANGE_OVF_EN adds the 3v+1 wrap indicator.
module collatz_step
  import collatz_range_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [VAL_W-1:0] load_val,
  output logic [VAL_W-1:0] v,
`ifdef COLLATZ_RANGE_OVF_EN
  output logic             wrap,
`endif
  output logic             next_is_one
);

  logic [VAL_W-1:0] tri_lo;
  logic [VAL_W-1:0] v_next;

`ifdef COLLATZ_RANGE_OVF_EN
  logic [VAL_W+1:0] triple;

  // Two guard bits catch any carry beyond 32 bits from 3v+1.
  assign triple = {2'b00, v} + {1'b0, v, 1'b0} + (VAL_W+2)'(1);
  assign tri_lo = triple[VAL_W-1:0];
  assign wrap   = v[0] & (triple[VAL_W+1:VAL_W] != 2'b00);
`else
  assign tri_lo = v + {v[VAL_W-2:0], 1'b0} + VAL_W'(1);
`endif

  assign v_next      = v[0] ? tri_lo : {1'b0, v[VAL_W-1:1]};
  assign next_is_one = (v_next == VAL_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else if (load) begin
      v <= load_val;
    end else if (step) begin
      v <= v_next;
    end
  end

endmodule

// File: rtl/collatz_range.sv
// Computes Collatz term counts for RAM_WORDS consecutive start values into a local RAM.
// Optional macro COLLATZ_RANGE_OVF_EN adds the sticky ovf output.
//
// state | meaning
// IDLE  | waiting for go after reset
// LOAD  | seed iterator with cur_n, steps = 1
// ITER  | one Collatz step per cycle until next value is 1
// WRITE | store count at index, advance or finish
// DONE  | run complete, done high, go restarts
module collatz_range
  import collatz_range_pkg::*;
#(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [31:0]              start,
  output logic                     done,
  input  logic [RAM_ADDR_BITS-1:0] raddr,
`ifdef COLLATZ_RANGE_OVF_EN
  output logic                     ovf,
`endif
  output logic [15:0]              rdata
);

  state_t state, state_nxt;

  logic [VAL_W-1:0]         cur_n;
  logic [RAM_ADDR_BITS-1:0] index;
  logic [COUNT_W-1:0]       steps;
  logic [VAL_W-1:0]         v;
  logic                     next_is_one;
  logic                     go_ok;
  logic                     last_idx;
  logic                     load_v;
  logic                     step_v;
  logic                     we;
  logic [COUNT_W-1:0]       wdata;
  logic [COUNT_W-1:0]       mem [RAM_WORDS];

`ifdef COLLATZ_RANGE_OVF_EN
  logic wrap;
`endif

  assign go_ok    = go && ((state == IDLE) || (state == DONE));
  assign last_idx = (index == RAM_ADDR_BITS'(RAM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    state_nxt = (cur_n <= VAL_W'(1)) ? WRITE : ITER;
      ITER:    if (next_is_one) state_nxt = WRITE;
      WRITE:   state_nxt = last_idx ? DONE : LOAD;
      DONE:    if (go) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done   = (state == DONE);
    load_v = (state == LOAD);
    step_v = (state == ITER);
    we     = (state == WRITE);
  end

  collatz_step u_step (
    .clk         (clk),
    .reset       (reset),
    .load        (load_v),
    .step        (step_v),
    .load_val    (cur_n),
    .v           (v),
`ifdef COLLATZ_RANGE_OVF_EN
    .wrap        (wrap),
`endif
    .next_is_one (next_is_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_n <= '0;
      index <= '0;
      steps <= '0;
    end else begin
      if (go_ok) begin
        cur_n <= start;
        index <= '0;
      end
      if (load_v) begin
        steps <= COUNT_W'(1);
      end
      // Counter pins at COUNT_MAX while the iteration keeps running to 1.
      if (step_v && (steps != COUNT_MAX)) begin
        steps <= steps + COUNT_W'(1);
      end
      if (we && !last_idx) begin
        index <= index + RAM_ADDR_BITS'(1);
        cur_n <= cur_n + VAL_W'(1);
      end
    end
  end

`ifdef COLLATZ_RANGE_OVF_EN
  always_ff @(posedge clk) begin
    if (reset || go_ok) begin
      ovf <= 1'b0;
    end else if (step_v && wrap) begin
      ovf <= 1'b1;
    end
  end
`endif

  // n = 0 never iterates and is recorded as zero terms.
  assign wdata = (cur_n == '0) ? '0 : steps;

  // Unreset RAM and read port: contents survive reset, read returns pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: tb/tb_collatz_range.sv
// Directed self-checking bench for collatz_range (default build or COLLATZ_RANGE_OVF_EN).
module tb_collatz_range;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [31:0] start;
  logic        done;
  logic [3:0]  raddr;
  logic [15:0] rdata;
`ifdef COLLATZ_RANGE_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  collatz_range #(.RAM_WORDS(16), .RAM_ADDR_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .start (start),
    .done  (done),
    .raddr (raddr),
`ifdef COLLATZ_RANGE_OVF_EN
    .ovf   (ovf),
`endif
    .rdata (rdata)
  );

  typedef struct {
    logic [31:0] start;
    int          idx;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_go(input logic [31:0] s);
    @(negedge clk);
    go    = 1'b1;
    start = s;
    @(negedge clk);
    go    = 1'b0;
  endtask

  task automatic run(input logic [31:0] s, input int budget);
    pulse_go(s);
    wait_done("run_done", budget);
  endtask

  task automatic rd(input int idx, output logic [15:0] d);
    @(negedge clk);
    raddr = 4'(idx);
    @(negedge clk);
    d = rdata;
  endtask

  task automatic rd_check(input string name, input int idx, input logic [15:0] exp);
    logic [15:0] d;
    rd(idx, d);
    check(name, {16'd0, d}, {16'd0, exp});
  endtask

  initial begin
    logic [31:0] prev;
    int          tab1 [16] = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};
    int          tab9 [16] = '{20, 7, 15, 10, 10, 18, 18, 5, 13, 21, 21, 8, 8, 16, 16, 11};

    vecs.push_back('{32'd27, 0, 16'd112});
    vecs.push_back('{32'd27, 1, 16'd19});
    for (int i = 0; i < 16; i++) vecs.push_back('{32'd1, i, 16'(tab1[i])});
    for (int i = 0; i < 16; i++) vecs.push_back('{32'd9, i, 16'(tab9[i])});
    vecs.push_back('{32'd0, 0, 16'd0});
    vecs.push_back('{32'd0, 1, 16'd1});
    vecs.push_back('{32'd0, 2, 16'd2});
    vecs.push_back('{32'd0, 7, 16'd17});
    vecs.push_back('{32'd0, 15, 16'd18});

    reset = 1'b1;
    go    = 1'b0;
    start = '0;
    raddr = '0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
`ifdef COLLATZ_RANGE_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    reset = 1'b0;

    prev = 32'hDEAD_BEEF;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].start != prev) begin
        run(vecs[i].start, 5000);
        prev = vecs[i].start;
      end
      rd_check($sformatf("tab_s%0d_i%0d", vecs[i].start, vecs[i].idx), vecs[i].idx, vecs[i].exp);
    end
`ifdef COLLATZ_RANGE_OVF_EN
    check("ovf_clean", {31'd0, ovf}, 32'd0);
`endif

    // Latency: index 0 currently holds 0, n=1 lands two cycles after go.
    @(negedge clk);
    raddr = 4'd0;
    go    = 1'b1;
    start = 32'd1;
    @(negedge clk);
    go    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lat_old", {16'd0, rdata}, 32'd0);
    check("lat_busy", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("lat_new", {16'd0, rdata}, 32'd1);
    wait_done("lat_done", 5000);

    run(32'hFFFF_FFF8, 40000);
    rd_check("wrap_n0", 8, 16'd0);
    rd_check("wrap_n1", 9, 16'd1);
    rd_check("wrap_n2", 10, 16'd2);
`ifdef COLLATZ_RANGE_OVF_EN
    check("wrap_ovf", {31'd0, ovf}, 32'd1);
`endif

    // go while iterating must be ignored.
    pulse_go(32'd27);
    repeat (5) @(negedge clk);
    go    = 1'b1;
    start = 32'd5;
    @(negedge clk);
    go    = 1'b0;
    wait_done("iter_done", 5000);
    rd_check("iter_i0", 0, 16'd112);
    rd_check("iter_i1", 1, 16'd19);
`ifdef COLLATZ_RANGE_OVF_EN
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
`endif

    pulse_go(32'd1);
    check("restart_done_low", {31'd0, done}, 32'd0);
    wait_done("restart_done", 5000);
    rd_check("restart_i2", 2, 16'd8);

    // Reset together with go mid-run.
    pulse_go(32'd27);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    go    = 1'b1;
    start = 32'd9;
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    go    = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_idle", {31'd0, done}, 32'd0);
    rd_check("rst_keep_i0", 0, 16'd1);
    rd_check("rst_keep_i15", 15, 16'd5);
    run(32'd9, 5000);
    rd_check("post_rst_i0", 0, 16'd20);
    rd_check("post_rst_i15", 15, 16'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
